// File: rtl/axi_stream_read_arbiter.sv
// Round-robin load arbiter over a shared AXI-Stream request/payload pair.
// N_CHANNELS load requesters share one single-beat request stream; returned
// payload beats are routed back in request order using a tag FIFO that
// records which channel issued each outstanding request.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ldAddr / ldAddr_valid / _ready   per-channel load address handshake
//   ldData / ldData_valid / _ready   per-channel returned data handshake
//   m_axis_req_*                     shared request stream (registered)
//   s_axis_pl_*                      shared payload stream
//   outstanding                      tag FIFO occupancy
//   err_unexpected                   sticky: payload beat with nothing outstanding
module axi_stream_read_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned N_CHANNELS      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0]  ldAddr,
  input  logic [N_CHANNELS-1:0]                  ldAddr_valid,
  output logic [N_CHANNELS-1:0]                  ldAddr_ready,
  output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]  ldData,
  output logic [N_CHANNELS-1:0]                  ldData_valid,
  input  logic [N_CHANNELS-1:0]                  ldData_ready,
  output logic [ADDR_WIDTH-1:0]                  m_axis_req_tdata,
  output logic                                   m_axis_req_tvalid,
  output logic                                   m_axis_req_tlast,
  input  logic                                   m_axis_req_tready,
  input  logic [DATA_WIDTH-1:0]                  s_axis_pl_tdata,
  input  logic                                   s_axis_pl_tvalid,
  input  logic                                   s_axis_pl_tlast,
  output logic                                   s_axis_pl_tready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_unexpected
);

  localparam int unsigned TAG_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [TAG_W-1:0]      last_grant;
  logic [TAG_W-1:0]      tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  err_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  can_accept;
  logic                  grant_found;
  logic [TAG_W-1:0]      grant_idx;
  logic [TAG_W-1:0]      cand;
  logic                  addr_hs;
  logic [TAG_W-1:0]      head;
  logic                  pop;

  // tlast carries no meaning here: every request is a single beat.
  logic unused_tlast;
  assign unused_tlast = s_axis_pl_tlast;

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  // Full blocks a push even if a pop happens this cycle (no bypass).
  assign can_accept = rst_n && (!req_valid || m_axis_req_tready) && !fifo_full;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= N_CHANNELS; k++) begin
      cand = TAG_W'((32'(last_grant) + k) % N_CHANNELS);
      if (!grant_found && ldAddr_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign addr_hs = grant_found && can_accept;

  always_comb begin
    ldAddr_ready = '0;
    if (addr_hs) ldAddr_ready[grant_idx] = 1'b1;
  end

  // Payload routing follows the oldest outstanding tag.
  assign head             = tag_mem[rd_ptr];
  assign s_axis_pl_tready = fifo_empty ? 1'b1 : ldData_ready[head];
  assign pop              = s_axis_pl_tvalid && !fifo_empty && ldData_ready[head];

  always_comb begin
    ldData_valid = '0;
    for (int unsigned j = 0; j < N_CHANNELS; j++) begin
      ldData[j]       = s_axis_pl_tdata;
      ldData_valid[j] = s_axis_pl_tvalid && !fifo_empty && (head == TAG_W'(j));
    end
  end

  // Request register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid  <= 1'b0;
      req_addr   <= '0;
      last_grant <= TAG_W'(N_CHANNELS - 1);
    end else if (addr_hs) begin
      req_valid  <= 1'b1;
      req_addr   <= ldAddr[grant_idx];
      last_grant <= grant_idx;
    end else if (m_axis_req_tready) begin
      req_valid  <= 1'b0;
    end
  end

  // Tag storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (addr_hs) tag_mem[wr_ptr] <= grant_idx;
  end

  // Tag FIFO pointers and occupancy; pointers wrap at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (addr_hs) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({addr_hs, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a payload beat discarded with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_q <= 1'b0;
    else if (s_axis_pl_tvalid && fifo_empty) err_q <= 1'b1;
  end

  assign m_axis_req_tvalid = req_valid;
  assign m_axis_req_tdata  = req_addr;
  assign m_axis_req_tlast  = 1'b1;
  assign outstanding       = count;
  assign err_unexpected    = err_q;

endmodule

// File: tb/tb_axi_stream_read_arbiter.sv
// Randomized scoreboard bench for axi_stream_read_arbiter.
module tb_axi_stream_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int OW = $clog2(MO + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0][AW-1:0]     ldAddr;
  logic [N-1:0]             ldAddr_valid;
  logic [N-1:0]             ldAddr_ready;
  logic [N-1:0][DW-1:0]     ldData;
  logic [N-1:0]             ldData_valid;
  logic [N-1:0]             ldData_ready;
  logic [AW-1:0]            m_axis_req_tdata;
  logic                     m_axis_req_tvalid;
  logic                     m_axis_req_tlast;
  logic                     m_axis_req_tready;
  logic [DW-1:0]            s_axis_pl_tdata;
  logic                     s_axis_pl_tvalid;
  logic                     s_axis_pl_tlast;
  logic                     s_axis_pl_tready;
  logic [OW-1:0]            outstanding;
  logic                     err_unexpected;

  axi_stream_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CHANNELS(N), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ldAddr(ldAddr), .ldAddr_valid(ldAddr_valid), .ldAddr_ready(ldAddr_ready),
    .ldData(ldData), .ldData_valid(ldData_valid), .ldData_ready(ldData_ready),
    .m_axis_req_tdata(m_axis_req_tdata), .m_axis_req_tvalid(m_axis_req_tvalid),
    .m_axis_req_tlast(m_axis_req_tlast), .m_axis_req_tready(m_axis_req_tready),
    .s_axis_pl_tdata(s_axis_pl_tdata), .s_axis_pl_tvalid(s_axis_pl_tvalid),
    .s_axis_pl_tlast(s_axis_pl_tlast), .s_axis_pl_tready(s_axis_pl_tready),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: in-order tag queue, pending request flag, RR pointer.
  int             m_tags[$];
  int             m_last;
  bit             m_pending;
  bit             m_err;
  logic [AW-1:0]  exp_req_q[$];
  int             exp_pl_ch[$];
  logic [DW-1:0]  exp_pl_d[$];

  bit             in_rst;
  logic [N-1:0]   hs_addr;
  bit             hs_pl;
  bit             allow_new;
  bit             clean;
  int             p_av, p_tr, p_pv, p_dr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model step: predict handshakes from the current inputs, then advance.
  always @(negedge clk) begin
    if (rst_n && !in_rst) begin
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_ldv;
      bit           found;
      int           g;
      bit           exp_plr;
      exp_rdy = '0;
      exp_ldv = '0;
      found   = 1'b0;
      g       = 0;
      if ((!m_pending || m_axis_req_tready) && m_tags.size() < MO) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && ldAddr_valid[c]) begin
            found = 1'b1;
            g     = c;
          end
        end
      end
      if (found) exp_rdy[g] = 1'b1;
      exp_plr = (m_tags.size() == 0) ? 1'b1 : ldData_ready[m_tags[0]];
      if (s_axis_pl_tvalid && m_tags.size() > 0) exp_ldv[m_tags[0]] = 1'b1;

      chk("addr_ready",  64'(ldAddr_ready), 64'(exp_rdy));
      chk("req_tvalid",  64'(m_axis_req_tvalid), 64'(m_pending));
      chk("outstanding", 64'(outstanding), 64'(m_tags.size()));
      chk("err_flag",    64'(err_unexpected), 64'(m_err));
      chk("pl_tready",   64'(s_axis_pl_tready), 64'(exp_plr));
      chk("data_valid",  64'(ldData_valid), 64'(exp_ldv));

      hs_addr = ldAddr_valid & ldAddr_ready;
      hs_pl   = s_axis_pl_tvalid && s_axis_pl_tready;

      if (m_pending && m_axis_req_tready) m_pending = 1'b0;
      if (found) begin
        exp_req_q.push_back(ldAddr[g]);
        m_pending = 1'b1;
        m_last    = g;
      end
      if (s_axis_pl_tvalid && exp_plr) begin
        if (m_tags.size() == 0) m_err = 1'b1;
        else begin
          exp_pl_ch.push_back(m_tags[0]);
          exp_pl_d.push_back(s_axis_pl_tdata);
          void'(m_tags.pop_front());
        end
      end
      if (found) m_tags.push_back(g);
    end
  end

  // Monitor: pops expected responses whenever the DUT completes a transfer.
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_data;
  always @(negedge clk) begin
    #2;
    if (rst_n && !in_rst) begin
      if (prev_stall)
        chk("req_hold", {59'd0, m_axis_req_tvalid, m_axis_req_tdata}, {59'd0, 1'b1, prev_data});
      if (m_axis_req_tvalid && m_axis_req_tready) begin
        chk("req_tlast", 64'(m_axis_req_tlast), 64'd1);
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_extra actual=%0h required=none t=%0t", m_axis_req_tdata, $time);
        end else chk("req_data", 64'(m_axis_req_tdata), 64'(exp_req_q.pop_front()));
      end
      prev_stall = m_axis_req_tvalid && !m_axis_req_tready;
      prev_data  = m_axis_req_tdata;
      for (int j = 0; j < N; j++) begin
        if (ldData_valid[j] && ldData_ready[j]) begin
          if (exp_pl_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_extra ch=%0d actual=%0h required=none t=%0t", j, ldData[j], $time);
          end else begin
            chk("data_ch",  64'(j), 64'(exp_pl_ch.pop_front()));
            chk("data_val", 64'(ldData[j]), 64'(exp_pl_d.pop_front()));
          end
        end
      end
    end else prev_stall = 1'b0;
  end

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (!ldAddr_valid[c] || hs_addr[c]) begin
        ldAddr_valid[c] = allow_new && ($urandom_range(99) < p_av);
        ldAddr[c]       = AW'($urandom);
      end
      ldData_ready[c] = ($urandom_range(99) < p_dr);
    end
    if (!s_axis_pl_tvalid || hs_pl) begin
      s_axis_pl_tvalid = ($urandom_range(99) < p_pv) && (!clean || m_tags.size() > 0);
      s_axis_pl_tdata  = $urandom;
      s_axis_pl_tlast  = 1'($urandom);
    end
    m_axis_req_tready = ($urandom_range(99) < p_tr);
    hs_addr = '0;
    hs_pl   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive();
    end
  endtask

  task automatic drain();
    int cnt;
    allow_new = 1'b0; clean = 1'b1;
    p_pv = 100; p_dr = 100; p_tr = 100;
    cnt = 0;
    while (cnt < 300 && !(m_tags.size() == 0 && !m_pending && ldAddr_valid == '0 &&
                          exp_req_q.size() == 0 && exp_pl_d.size() == 0 && !s_axis_pl_tvalid)) begin
      run(1);
      cnt++;
    end
    checks++;
    if (cnt >= 300) begin
      errors++;
      $display("FAIL drain_timeout tags=%0d reqs=%0d beats=%0d", m_tags.size(), exp_req_q.size(), exp_pl_d.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n  = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("rst_req_tvalid",  64'(m_axis_req_tvalid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_addr_ready",  64'(ldAddr_ready), 64'd0);
    chk("rst_data_valid",  64'(ldData_valid), 64'd0);
    chk("rst_err",         64'(err_unexpected), 64'd0);
    m_tags.delete(); exp_req_q.delete(); exp_pl_ch.delete(); exp_pl_d.delete();
    m_last = N - 1; m_pending = 1'b0; m_err = 1'b0;
    hs_addr = '0; hs_pl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic knobs(input bit cl, input int av, input int tr, input int pv, input int dr);
    allow_new = 1'b1; clean = cl;
    p_av = av; p_tr = tr; p_pv = pv; p_dr = dr;
  endtask

  initial begin
    rst_n = 1'b0; in_rst = 1'b1;
    ldAddr = '0; ldAddr_valid = '0; ldData_ready = '0;
    m_axis_req_tready = 1'b0;
    s_axis_pl_tdata = '0; s_axis_pl_tvalid = 1'b0; s_axis_pl_tlast = 1'b0;
    hs_addr = '0; hs_pl = 1'b0;
    allow_new = 1'b0; clean = 1'b1; p_av = 0; p_tr = 0; p_pv = 0; p_dr = 0;
    do_reset();

    // All channels requesting, no payload: RR order, then FIFO-full backpressure.
    knobs(1'b1, 100, 100, 0, 100);
    run(10);
    drain();

    knobs(1'b1, 50, 70, 60, 70);
    run(400);
    drain();

    knobs(1'b1, 60, 30, 80, 30);
    run(400);
    drain();

    // Unexpected beats allowed: sticky error path.
    knobs(1'b0, 40, 80, 50, 60);
    run(200);
    drain();

    // Reset mid-operation with requests in flight.
    knobs(1'b1, 100, 100, 0, 100);
    begin
      int cnt;
      cnt = 0;
      while (cnt < 20 && m_tags.size() < 2) begin run(1); cnt++; end
      checks++;
      if (m_tags.size() < 2) begin
        errors++;
        $display("FAIL fill_timeout actual=%0d required=2", m_tags.size());
      end
    end
    do_reset();
    knobs(1'b1, 100, 100, 0, 100);
    run(6);
    drain();

    knobs(1'b1, 70, 60, 70, 50);
    run(300);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog time=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
